// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM port arbiter: arbiter states, owner status codes, read tags.
// No logic; latency and backpressure are defined by the modules that import it.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    localparam logic TAG_M0 = 1'b0;
    localparam logic TAG_M1 = 1'b1;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Owner-tag FIFO: one bit per outstanding read, naming the master that issued it.
// Latency: push visible at head next cycle; head is read combinationally.
// Backpressure: full/empty are judged on the registered count; push+pop in one cycle keeps the count.
module sdram_arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop does not free a slot for a push in the same cycle.
    assign do_push = push && !full;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter for one SDRAM controller port: m0 fixed priority, m1 starvation guard.
// Latency: 1 cycle request-to-command, min 2 cycles per transfer; read data routed same cycle by tag.
// Backpressure: s_waitrequest holds the grant and is passed to the granted master; reads stall while tag FIFO full.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 16,
    parameter int BE_W         = 2,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,

    output logic [1:0]        owner,
    output logic              err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t state;
    arb_state_t state_nxt;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_head;
    logic          fifo_push;
    logic          fifo_pop;
    logic          push_tag;

    logic          m0_req;
    logic          m1_req;
    logic          m1_starved;
    logic          m0_busy;
    logic          presented;
    logic          accept;
    logic          both_rw;
    logic [SW-1:0] starve_cnt;

    // A read counts as a request only if a tag slot is free at the start of the cycle.
    assign m0_req     = m0_read ? !fifo_full : m0_write;
    assign m1_req     = m1_read ? !fifo_full : m1_write;
    assign m1_starved = m1_req && (starve_cnt >= SW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        presented      = 1'b0;
        both_rw        = 1'b0;
        push_tag       = TAG_M0;
        owner          = OWNER_IDLE;

        unique case (state)
            IDLE: begin
                if (m0_req && !m1_starved) begin
                    state_nxt = GRANT0;
                end else if (m1_req) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read;
                s_write        = m0_write && !m0_read;
                m0_waitrequest = s_waitrequest;
                presented      = m0_read || m0_write;
                both_rw        = m0_read && m0_write;
                push_tag       = TAG_M0;
                owner          = OWNER_M0;
            end
            GRANT1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read;
                s_write        = m1_write && !m1_read;
                m1_waitrequest = s_waitrequest;
                presented      = m1_read || m1_write;
                both_rw        = m1_read && m1_write;
                push_tag       = TAG_M1;
                owner          = OWNER_M1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        accept = presented && !s_waitrequest;
        // A granted master that withdraws its request releases the port rather than locking it.
        if ((state != IDLE) && (accept || !presented)) begin
            state_nxt = IDLE;
        end
    end

    assign fifo_push = accept && s_read;
    assign fifo_pop  = s_readdatavalid && !fifo_empty;

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_tag (push_tag),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = fifo_pop && (fifo_head == TAG_M0);
    assign m1_readdatavalid = fifo_pop && (fifo_head == TAG_M1);

    // m1 is blocked both on the cycle m0 is picked and on m0's transfer cycle.
    assign m0_busy = (state == GRANT0) || ((state == IDLE) && (state_nxt == GRANT0));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if ((state == GRANT1) && accept) begin
            starve_cnt <= '0;
        end else if (m1_req && m0_busy && (starve_cnt < SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (both_rw || (s_readdatavalid && fifo_empty)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter against a transaction-level reference model.
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;
    localparam int MAXP   = 4;
    localparam int LIMIT  = 8;

    logic clk = 1'b0;
    logic reset_n;

    logic [ADDR_W-1:0] m_addr  [2];
    logic [DATA_W-1:0] m_wdata [2];
    logic [BE_W-1:0]   m_be    [2];
    logic [1:0]        m_rd;
    logic [1:0]        m_wr;
    logic [1:0]        m_wait;
    logic [1:0]        m_rdv;
    logic [DATA_W-1:0] m0_rdata;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] s_addr;
    logic              s_rd;
    logic              s_wr;
    logic [DATA_W-1:0] s_wdata;
    logic [BE_W-1:0]   s_be;
    logic              s_wait;
    logic [DATA_W-1:0] s_rdata;
    logic              s_rdv;
    logic [1:0]        owner;
    logic              err;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .MAX_PENDING(MAXP), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m_addr[0]),
        .m0_read          (m_rd[0]),
        .m0_write         (m_wr[0]),
        .m0_writedata     (m_wdata[0]),
        .m0_byteenable    (m_be[0]),
        .m0_waitrequest   (m_wait[0]),
        .m0_readdata      (m0_rdata),
        .m0_readdatavalid (m_rdv[0]),
        .m1_address       (m_addr[1]),
        .m1_read          (m_rd[1]),
        .m1_write         (m_wr[1]),
        .m1_writedata     (m_wdata[1]),
        .m1_byteenable    (m_be[1]),
        .m1_waitrequest   (m_wait[1]),
        .m1_readdata      (m1_rdata),
        .m1_readdatavalid (m_rdv[1]),
        .s_address        (s_addr),
        .s_read           (s_rd),
        .s_write          (s_wr),
        .s_writedata      (s_wdata),
        .s_byteenable     (s_be),
        .s_waitrequest    (s_wait),
        .s_readdata       (s_rdata),
        .s_readdatavalid  (s_rdv),
        .owner            (owner),
        .err              (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the port (-1 none), outstanding read owners, blocked-cycle count, sticky error.
    int   served = -1;
    bit   q[$];
    int   starve = 0;
    bit   merr   = 1'b0;
    bit [1:0] busy = 2'b00;
    bit [1:0] last_wait = 2'b11;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit [1:0] req;
        bit [1:0] e_wait;
        bit [1:0] e_rdv;
        bit       full, e_sr, e_sw, pres, acc, pop, push, m0_busy, rw_err;
        logic [1:0] e_owner;
        int       nxt;
        #4;
        full = (q.size() >= MAXP);
        for (int i = 0; i < 2; i++) req[i] = m_rd[i] ? !full : m_wr[i];
        e_wait = 2'b11; e_sr = 0; e_sw = 0; e_owner = 2'b00;
        pres = 0; acc = 0; push = 0; rw_err = 0;
        if (served >= 0) begin
            e_sr = m_rd[served];
            e_sw = m_wr[served] && !m_rd[served];
            e_wait[served] = s_wait;
            e_owner = (served == 0) ? 2'b01 : 2'b10;
            pres = m_rd[served] || m_wr[served];
            acc  = pres && !s_wait;
            push = acc && m_rd[served];
            rw_err = m_rd[served] && m_wr[served];
            check("s_address", 32'(s_addr), 32'(m_addr[served]));
            check("s_writedata", 32'(s_wdata), 32'(m_wdata[served]));
            check("s_byteenable", 32'(s_be), 32'(m_be[served]));
        end
        e_rdv = 2'b00;
        if (s_rdv && q.size() > 0) e_rdv[q[0]] = 1'b1;
        check("s_read", 32'(s_rd), 32'(e_sr));
        check("s_write", 32'(s_wr), 32'(e_sw));
        check("waitrequest", 32'(m_wait), 32'(e_wait));
        check("readdatavalid", 32'(m_rdv), 32'(e_rdv));
        check("m0_readdata", 32'(m0_rdata), 32'(s_rdata));
        check("m1_readdata", 32'(m1_rdata), 32'(s_rdata));
        check("owner", 32'(owner), 32'(e_owner));
        check("err", 32'(err), 32'(merr));
        last_wait = e_wait;

        if (served < 0) begin
            if (req[0] && !(req[1] && starve >= LIMIT)) nxt = 0;
            else if (req[1]) nxt = 1;
            else nxt = -1;
        end else begin
            nxt = (acc || !pres) ? -1 : served;
        end
        m0_busy = (served == 0) || (served < 0 && nxt == 0);
        pop = s_rdv && q.size() > 0;

        @(posedge clk);
        if (!reset_n) begin
            served = -1; q.delete(); starve = 0; merr = 0;
        end else begin
            merr = merr | (s_rdv && q.size() == 0) | rw_err;
            if (served == 1 && acc) starve = 0;
            else if (req[1] && m0_busy && starve < LIMIT) starve++;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(served == 1);
            served = nxt;
        end
        #1;
    endtask

    task automatic gen(input int p_req, input int p_wait, input int p_rdv, input bit both_ok, input int p_rst);
        for (int i = 0; i < 2; i++) begin
            if (!busy[i]) begin
                if ($urandom_range(0, 99) < p_req) begin
                    busy[i]   = 1'b1;
                    m_rd[i]   = $urandom_range(0, 1) == 1;
                    m_wr[i]   = !m_rd[i];
                    if (both_ok && $urandom_range(0, 19) == 0) begin
                        m_rd[i] = 1'b1;
                        m_wr[i] = 1'b1;
                    end
                    m_addr[i]  = ADDR_W'($urandom);
                    m_wdata[i] = DATA_W'($urandom);
                    m_be[i]    = BE_W'($urandom);
                end else begin
                    m_rd[i] = 1'b0;
                    m_wr[i] = 1'b0;
                end
            end
        end
        s_wait  = $urandom_range(0, 99) < p_wait;
        s_rdv   = (q.size() > 0) && ($urandom_range(0, 99) < p_rdv);
        s_rdata = DATA_W'($urandom);
        reset_n = !($urandom_range(0, 999) < p_rst);
        step();
        for (int i = 0; i < 2; i++) if (busy[i] && !last_wait[i]) busy[i] = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic idle_inputs();
        m_rd = 2'b00; m_wr = 2'b00; s_wait = 1'b0; s_rdv = 1'b0; s_rdata = '0;
        busy = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = '0;
        end
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state, then single m0 read returned with 0x1234.
        step();
        m_rd[0] = 1'b1; m_addr[0] = 25'h0ABCDE;
        step();
        step();
        m_rd[0] = 1'b0;
        step();
        step();
        s_rdv = 1'b1; s_rdata = 16'h1234;
        step();
        s_rdv = 1'b0;
        step();

        repeat (600) gen(50, 30, 40, 1'b0, 0);
        repeat (200) gen(100, 0, 60, 1'b0, 0);
        repeat (200) gen(80, 0, 5, 1'b0, 0);
        repeat (200) gen(70, 80, 40, 1'b0, 0);
        repeat (300) gen(60, 30, 40, 1'b0, 10);

        for (int k = 0; k < 100 && (busy != 2'b00 || q.size() != 0); k++) gen(0, 0, 100, 1'b0, 0);
        check("drained", 32'(q.size()), 32'd0);

        // Spurious readdatavalid sets a sticky error that only reset clears.
        idle_inputs();
        s_rdv = 1'b1; s_rdata = 16'hDEAD;
        step();
        s_rdv = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (2) step();

        repeat (300) gen(60, 30, 40, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
